// File: rtl/wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_bram_ctrl
//
// Wishbone B4 slave in front of a simple dual-port, byte-strobed block RAM.
// The RAM has one write port and one registered read port with 1-cycle read
// latency. Classic single cycles and registered-feedback bursts (linear,
// wrap4, wrap8, wrap16) become RAM port activity. Inside a burst the slave
// sustains one beat per cycle.
//
// Handshake: a request is offered when wb_cyc & wb_stb. A classic request is
// accepted in IDLE and acknowledged one cycle later. Inside a burst a beat is
// accepted and acknowledged in the same cycle, provided its address and
// direction match the expected next beat. wb_dat_r is meaningful only while
// wb_ack is high.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wb_adr/wb_dat_w     word address / write data from the master
//   wb_dat_r            read data (straight from mem_rdata)
//   wb_sel/wb_we        byte selects / write enable
//   wb_cyc/wb_stb       cycle valid / strobe
//   wb_cti/wb_bte       cycle type / burst type
//   wb_ack              acknowledge
//   mem_wstrb/waddr/wdata  RAM write port
//   mem_raddr/mem_rdata    RAM read port (data one cycle after address)
//   dbg_state           current FSM state (0 IDLE, 1 ACK, 2 BURST)
// -----------------------------------------------------------------------------
module wb_bram_ctrl #(
    parameter int SIZE = 1024,
    parameter int COLS = 4,
    parameter int AW   = $clog2(SIZE),
    parameter int DW   = COLS * 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   wb_adr,
    input  logic [DW-1:0]   wb_dat_w,
    output logic [DW-1:0]   wb_dat_r,
    input  logic [COLS-1:0] wb_sel,
    input  logic            wb_we,
    input  logic            wb_cyc,
    input  logic            wb_stb,
    input  logic [2:0]      wb_cti,
    input  logic [1:0]      wb_bte,
    output logic            wb_ack,
    output logic [COLS-1:0] mem_wstrb,
    output logic [AW-1:0]   mem_waddr,
    output logic [DW-1:0]   mem_wdata,
    output logic [AW-1:0]   mem_raddr,
    input  logic [DW-1:0]   mem_rdata,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] baddr_q, baddr_d;   // address of the next expected beat
    logic          bwe_q,   bwe_d;     // burst direction
    logic [1:0]    bte_q,   bte_d;     // burst wrap type
    logic          burst_q, burst_d;   // request in IDLE opened a burst

    logic          beat_ok;

    // Next beat address: wrap-N bursts only advance the low log2(N) bits,
    // linear bursts advance the whole address modulo 2^AW.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                 input logic [1:0]    bte);
        logic [AW-1:0] mask;
        logic [AW-1:0] inc;
        case (bte)
            2'b01:   mask = AW'(3);
            2'b10:   mask = AW'(7);
            2'b11:   mask = AW'(15);
            default: mask = '1;
        endcase
        inc = a + AW'(1);
        return (a & ~mask) | (inc & mask);
    endfunction

    // Write port and read data are pass-throughs; only the strobes and the
    // read address are steered by the FSM.
    assign mem_waddr = wb_adr;
    assign mem_wdata = wb_dat_w;
    assign wb_dat_r  = mem_rdata;
    assign dbg_state = state_q;

    assign beat_ok = wb_cyc && wb_stb && (wb_adr == baddr_q) && (wb_we == bwe_q);

    always_comb begin
        state_d   = state_q;
        baddr_d   = baddr_q;
        bwe_d     = bwe_q;
        bte_d     = bte_q;
        burst_d   = burst_q;
        wb_ack    = 1'b0;
        mem_wstrb = '0;
        mem_raddr = wb_adr;

        case (state_q)
            S_IDLE: begin
                mem_raddr = wb_adr;
                if (wb_cyc && wb_stb) begin
                    if (wb_we) begin
                        mem_wstrb = wb_sel;
                    end
                    baddr_d = next_addr(wb_adr, wb_bte);
                    bwe_d   = wb_we;
                    bte_d   = wb_bte;
                    burst_d = (wb_cti == 3'b010);
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                wb_ack = wb_cyc;
                // Prefetch the second beat so a burst can run back-to-back.
                mem_raddr = baddr_q;
                state_d   = (burst_q && wb_cyc) ? S_BURST : S_IDLE;
            end

            S_BURST: begin
                if (beat_ok) begin
                    wb_ack = 1'b1;
                    if (bwe_q) begin
                        mem_wstrb = wb_sel;
                    end
                    baddr_d   = next_addr(baddr_q, bte_q);
                    mem_raddr = baddr_d;
                    if (wb_cti == 3'b111) begin
                        state_d = S_IDLE;
                    end
                end else if (wb_cyc && !wb_stb) begin
                    // Wait state: keep the expected beat's data prefetched.
                    mem_raddr = baddr_q;
                end else begin
                    // Dropped cycle or out-of-sequence beat: the request, if
                    // any, is served again from IDLE as a fresh cycle.
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset silences the bus immediately, before the state flop settles.
        if (rst) begin
            wb_ack    = 1'b0;
            mem_wstrb = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baddr_q <= '0;
            bwe_q   <= 1'b0;
            bte_q   <= 2'b00;
            burst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baddr_q <= baddr_d;
            bwe_q   <= bwe_d;
            bte_q   <= bte_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_bram_ctrl
//
// Directed bench for wb_bram_ctrl. A behavioural block RAM (registered read,
// read-first, preloaded with word = address) sits on the mem_* ports. Inputs
// change on the falling edge; outputs are sampled 2-3 time units later, well
// away from the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_bram_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [AW-1:0] wb_adr   = '0;
    logic [DW-1:0] wb_dat_w = '0;
    logic [DW-1:0] wb_dat_r;
    logic [3:0]    wb_sel   = '0;
    logic          wb_we    = 1'b0;
    logic          wb_cyc   = 1'b0;
    logic          wb_stb   = 1'b0;
    logic [2:0]    wb_cti   = 3'b000;
    logic [1:0]    wb_bte   = 2'b00;
    logic          wb_ack;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    dbg_state;

    wb_bram_ctrl #(.SIZE(1024), .COLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_dat_r  (wb_dat_r),
        .wb_sel    (wb_sel),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_cti    (wb_cti),
        .wb_bte    (wb_bte),
        .wb_ack    (wb_ack),
        .mem_wstrb (mem_wstrb),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram [1024];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] <= 32'(i);
        end
        mem_rdata <= '0;
        forever begin
            @(posedge clk);
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    ram[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
            mem_rdata <= ram[mem_raddr];
        end
    end

    // ---------------- scoring ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Watchdog: the bench has no open-ended waits, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Beat address / data tables for bursts (read: expected data).
    logic [AW-1:0] badr [8];
    logic [DW-1:0] bdat [8];

    task automatic classic_access(input string tag, input logic we, input logic [AW-1:0] adr,
                                  input logic [DW-1:0] dat, input logic [3:0] sel,
                                  input logic [DW-1:0] exp_rd);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr;
        wb_dat_w = dat; wb_sel = sel; wb_cti = 3'b000; wb_bte = 2'b00;
        #2;
        chk({tag, " req ack"}, 32'(wb_ack), 32'd0);
        chk({tag, " req wstrb"}, 32'(mem_wstrb), 32'(we ? sel : 4'h0));
        @(negedge clk); #2;
        chk({tag, " ack"}, 32'(wb_ack), 32'd1);
        chk({tag, " ack wstrb"}, 32'(mem_wstrb), 32'd0);
        if (!we) begin
            chk({tag, " rdata"}, wb_dat_r, exp_rd);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    // Registered-feedback burst of n beats from badr/bdat. Optional wait
    // states (gap_len cycles of stb low after beat gap_after) and optional
    // abort (cyc dropped after beat stop_after). Pass -1 to disable.
    task automatic run_burst(input string tag, input logic we, input logic [1:0] bte,
                             input int n, input int gap_after, input int gap_len,
                             input int stop_after);
        for (int i = 0; i < n; i++) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = 4'hF; wb_bte = bte;
            wb_adr = badr[i]; wb_dat_w = we ? bdat[i] : 32'h0;
            wb_cti = (i == n - 1) ? 3'b111 : 3'b010;
            #2;
            if (i == 0) begin
                chk($sformatf("%s b0 req ack", tag), 32'(wb_ack), 32'd0);
                chk($sformatf("%s b0 req wstrb", tag), 32'(mem_wstrb), 32'(we ? 4'hF : 4'h0));
                @(negedge clk); #2;
            end
            chk($sformatf("%s b%0d ack", tag, i), 32'(wb_ack), 32'd1);
            if (we) begin
                chk($sformatf("%s b%0d wstrb", tag, i), 32'(mem_wstrb),
                    32'((i == 0) ? 4'h0 : 4'hF));
            end else begin
                chk($sformatf("%s b%0d rdata", tag, i), wb_dat_r, bdat[i]);
            end
            @(negedge clk);
            if (i == stop_after) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
                #2;
                chk($sformatf("%s abort ack", tag), 32'(wb_ack), 32'd0);
                chk($sformatf("%s abort wstrb", tag), 32'(mem_wstrb), 32'd0);
                @(negedge clk); #2;
                chk($sformatf("%s abort idle", tag), 32'(dbg_state), 32'd0);
                chk($sformatf("%s abort ack2", tag), 32'(wb_ack), 32'd0);
                return;
            end
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    wb_stb = 1'b0; wb_adr = badr[i+1];
                    #2;
                    chk($sformatf("%s gap%0d ack", tag, g), 32'(wb_ack), 32'd0);
                    chk($sformatf("%s gap%0d state", tag, g), 32'(dbg_state), 32'd2);
                    @(negedge clk);
                end
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000; wb_we = 1'b0;
        #2;
        chk({tag, " end idle"}, 32'(dbg_state), 32'd0);
        chk({tag, " end ack"}, 32'(wb_ack), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset, with a write request on the bus that must not strobe.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
        wb_adr = 10'h155; wb_dat_w = 32'hFFFF_FFFF;
        @(negedge clk); #2;
        chk("rst ack", 32'(wb_ack), 32'd0);
        chk("rst wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        chk("rst raddr", 32'(mem_raddr), 32'h155);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0; wb_adr = '0;
        rst = 1'b0;
        @(negedge clk);

        // Classic write then back-to-back classic read.
        classic_access("wr010", 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, 32'h0);
        classic_access("rd010", 1'b0, 10'h010, 32'h0, 4'hF, 32'hDEAD_BEEF);

        // Byte-lane write over an existing word.
        classic_access("wr020", 1'b1, 10'h020, 32'h1122_3344, 4'hF, 32'h0);
        classic_access("wr020b", 1'b1, 10'h020, 32'h00AA_0000, 4'b0100, 32'h0);
        classic_access("rd020", 1'b0, 10'h020, 32'h0, 4'hF, 32'h11AA_3344);

        // Linear read burst crossing the top of the address space.
        badr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h0, 10'h0, 10'h0, 10'h0};
        bdat = '{32'h3FE, 32'h3FF, 32'h000, 32'h001, 32'h0, 32'h0, 32'h0, 32'h0};
        run_burst("lin_rd", 1'b0, 2'b00, 4, -1, 0, -1);

        // Wrap4 write burst from 0x006, then read back each word.
        badr = '{10'h006, 10'h007, 10'h004, 10'h005, 10'h0, 10'h0, 10'h0, 10'h0};
        bdat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'h0};
        run_burst("wrap4_wr", 1'b1, 2'b01, 4, -1, 0, -1);
        classic_access("rd004", 1'b0, 10'h004, 32'h0, 4'hF, 32'hA2);
        classic_access("rd005", 1'b0, 10'h005, 32'h0, 4'hF, 32'hA3);
        classic_access("rd006", 1'b0, 10'h006, 32'h0, 4'hF, 32'hA0);
        classic_access("rd007", 1'b0, 10'h007, 32'h0, 4'hF, 32'hA1);

        // Wrap8 read burst from 0x00E.
        badr = '{10'h00E, 10'h00F, 10'h008, 10'h009, 10'h00A, 10'h0, 10'h0, 10'h0};
        bdat = '{32'h00E, 32'h00F, 32'h008, 32'h009, 32'h00A, 32'h0, 32'h0, 32'h0};
        run_burst("wrap8_rd", 1'b0, 2'b10, 5, -1, 0, -1);

        // Read burst with two wait states after the first beat.
        badr = '{10'h030, 10'h031, 10'h032, 10'h033, 10'h0, 10'h0, 10'h0, 10'h0};
        bdat = '{32'h030, 32'h031, 32'h032, 32'h033, 32'h0, 32'h0, 32'h0, 32'h0};
        run_burst("gap_rd", 1'b0, 2'b00, 4, 0, 2, -1);

        // 8-beat write burst aborted after beat 2.
        badr = '{10'h040, 10'h041, 10'h042, 10'h043, 10'h044, 10'h045, 10'h046, 10'h047};
        bdat = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
        run_burst("abort_wr", 1'b1, 2'b00, 8, -1, 0, 1);
        classic_access("rd041", 1'b0, 10'h041, 32'h0, 4'hF, 32'hB1);
        classic_access("rd042", 1'b0, 10'h042, 32'h0, 4'hF, 32'h042);

        // Reset pulse in the middle of a read burst.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
        wb_adr = 10'h050; wb_cti = 3'b010; wb_bte = 2'b00;
        @(negedge clk); #2;
        chk("rstb b0 ack", 32'(wb_ack), 32'd1);
        chk("rstb b0 rdata", wb_dat_r, 32'h050);
        @(negedge clk);
        wb_adr = 10'h051;
        #2;
        chk("rstb b1 ack", 32'(wb_ack), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstb async ack", 32'(wb_ack), 32'd0);
        chk("rstb async state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
        @(negedge clk);
        classic_access("post_rst_rd", 1'b0, 10'h010, 32'h0, 4'hF, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
